// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : 8-digit seven-segment scan controller with a frame-synchronous
//            double-buffered display word. Optional macro SEG_SCAN_LZ_BLANK_EN
//            enables leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              hex_out,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WW = 4 * NUM_DIGITS;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_DIGITS - 1);

  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [WW-1:0]          disp_q, disp_d;
  logic [NUM_DIGITS-1:0]  dpr_q, dpr_d;
  logic [WW+NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                   pending_q, pending_d;
  logic [3:0]             hex_q, hex_d;
  logic [NUM_DIGITS-1:0]  anode_q, anode_d;
  logic                   dp_q, dp_d;
  logic                   frame_done_q, frame_done_d;

  logic                   tick;
  logic                   boundary;
  logic [3:0]             sel_nib;
  logic                   sel_dp;
  logic [NUM_DIGITS-1:0]  one_cold;
`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [PW-1:0]          msd;
`endif

  always_comb begin
    tick     = (div_cnt_q == DIV_LAST);
    boundary = tick && (ptr_q == PTR_LAST);

    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    ptr_d     = ptr_q;
    if (tick) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    end

    // The boundary consumes the shadow as it stood before this cycle's load.
    disp_d    = disp_q;
    dpr_d     = dpr_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (boundary && pending_q) begin
      {disp_d, dpr_d} = shadow_q;
      pending_d       = 1'b0;
    end
    if (load) begin
      shadow_d  = {data_in, dp_in};
      pending_d = 1'b1;
    end

    sel_nib  = 4'h0;
    sel_dp   = 1'b0;
    one_cold = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (ptr_d == PW'(k)) begin
        sel_nib     = disp_d[4*k +: 4];
        sel_dp      = dpr_d[k];
        one_cold[k] = 1'b0;
      end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    msd = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((disp_d[4*k +: 4] != 4'h0) || dpr_d[k]) begin
        msd = PW'(k);
      end
    end
    if (ptr_d > msd) begin
      one_cold = '1;
    end
`endif

    // Outputs only move on a tick, so they stay dark until the first one.
    hex_d        = hex_q;
    anode_d      = anode_q;
    dp_d         = dp_q;
    frame_done_d = boundary;
    if (tick) begin
      hex_d   = sel_nib;
      anode_d = one_cold;
      dp_d    = ~sel_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      ptr_q        <= PTR_LAST;
      disp_q       <= '0;
      dpr_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      hex_q        <= 4'h0;
      anode_q      <= '1;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      ptr_q        <= ptr_d;
      disp_q       <= disp_d;
      dpr_q        <= dpr_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      hex_q        <= hex_d;
      anode_q      <= anode_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign hex_out    = hex_q;
  assign anode      = anode_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Scoreboard bench for seg_scan_ctrl (REFRESH_DIV=4, NUM_DIGITS=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int RD = 4;
  localparam int ND = 8;
  localparam int FRAME = RD * ND;

  typedef logic [13:0] obs_t;   // {anode, hex_out, dp, frame_done}
  localparam obs_t RST_OBS = {8'hFF, 4'h0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic [3:0]  hex_out;
  logic [7:0]  anode;
  logic        dp;
  logic        frame_done;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .hex_out    (hex_out),
    .anode      (anode),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference state: edges counted since reset release, and the word on show.
  int          edge_n = 0;
  logic [31:0] shown_w = '0, pend_w = '0;
  logic [7:0]  shown_dp = '0, pend_dp = '0;
  bit          pend_v = 1'b0;
  obs_t        exp_q[$];

  function automatic obs_t expect_at(input int e);
    int       d;
    logic [7:0] an;
    if (e < RD) return RST_OBS;
    d  = ((e / RD) - 1) % ND;
    an = ~(8'h01 << d);
`ifdef SEG_SCAN_LZ_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int k = 0; k < ND; k++)
        if (shown_w[4*k +: 4] != 4'h0 || shown_dp[k]) msd = k;
      if (d > msd) an = 8'hFF;
    end
`endif
    return {an, shown_w[4*d +: 4], ~shown_dp[d], ((e % FRAME) == RD)};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        edge_n   = 0;
        pend_v   = 1'b0;
        pend_w   = '0;
        pend_dp  = '0;
        shown_w  = '0;
        shown_dp = '0;
      end else begin
        edge_n++;
        if ((edge_n % FRAME) == RD && pend_v) begin
          shown_w  = pend_w;
          shown_dp = pend_dp;
          pend_v   = 1'b0;
        end
        exp_q.push_back(expect_at(edge_n));
        if (load) begin
          pend_w  = data_in;
          pend_dp = dp_in;
          pend_v  = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin : sample
      obs_t x;
      @(negedge clk);
      if (!rst_n) begin
        chk_val("reset_hold", 32'({anode, hex_out, dp, frame_done}), 32'(RST_OBS));
      end else if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk_val($sformatf("scan_e%0d", edge_n), 32'({anode, hex_out, dp, frame_done}), 32'(x));
      end
    end
  end

  task automatic wait_edge(input int target);
    int guard;
    guard = 0;
    while (edge_n < target) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        chk_val("wait_timeout", 32'(edge_n), 32'(target));
        return;
      end
    end
  endtask

  // Drive load so that the DUT captures it on edge at_edge.
  task automatic do_load(input logic [31:0] word, input logic [7:0] dpv, input int at_edge);
    wait_edge(at_edge - 1);
    load    = 1'b1;
    data_in = word;
    dp_in   = dpv;
    @(negedge clk);
    load    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_load(32'h7654_3210, 8'h05, 10);
    wait_edge(70);

    do_load(32'hAAAA_AAAA, 8'h00, 81);
    wait_edge(105);

    do_load(32'h1111_1111, 8'h80, 110);
    do_load(32'h2222_2222, 8'h01, 132);
    wait_edge(200);

    do_load(32'h3333_3333, 8'hFF, 205);
    wait_edge(217);
    #2 rst_n = 1'b0;
    #1 chk_val("async_rst", 32'({anode, hex_out, dp, frame_done}), 32'(RST_OBS));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_edge(72);

    do_load(32'h0000_00A5, 8'h00, 80);
    wait_edge(150);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
